// File: rtl/dh_session_ctrl_if.sv
// Engine-side bus between dh_session_ctrl and the shared modular-exponentiation engine.
//   eng_base   : base operand (controller -> engine)
//   eng_exp    : exponent operand, W+1 bits (controller -> engine)
//   eng_prime  : modulus (controller -> engine)
//   eng_load   : one-cycle load/reset pulse (controller -> engine)
//   eng_busy   : engine dirty flag, high while computing (engine -> controller)
//   eng_result : result, valid once eng_busy is low (engine -> controller)
interface dh_session_ctrl_if #(
  parameter int unsigned W = 100
) ();
  logic [W-1:0] eng_base;
  logic [W:0]   eng_exp;
  logic [W-1:0] eng_prime;
  logic         eng_load;
  logic         eng_busy;
  logic [W-1:0] eng_result;

  modport master (
    output eng_base, eng_exp, eng_prime, eng_load,
    input  eng_busy, eng_result
  );

  modport slave (
    input  eng_base, eng_exp, eng_prime, eng_load,
    output eng_busy, eng_result
  );
endinterface

// File: rtl/dh_session_ctrl.sv
// Diffie-Hellman session controller. Runs g^a mod p on the shared exponentiation engine,
// accepts and range-checks the peer key B, then runs B^a mod p. Owns engine sequencing,
// result capture and per-exponentiation timeout supervision.
//   clk, rst          : clock, asynchronous active-high reset
//   start, abort      : begin session (IDLE only) / synchronous return to IDLE
//   gen, prime, priv  : g, p, a; captured on accepted start
//   peer_pub/valid/ready : peer public key handshake
//   pub_key/valid, shared_key/valid : results, held until the next accepted start
//   busy, error, err_code : status; error sticky until next accepted start
//   eng               : engine bus (master side)
module dh_session_ctrl #(
  parameter int unsigned W       = 100,
  parameter int unsigned TIMEOUT = 1 << 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [W-1:0]      gen,
  input  logic [W-1:0]      prime,
  input  logic [W:0]        priv,
  input  logic [W-1:0]      peer_pub,
  input  logic              peer_valid,
  output logic              peer_ready,
  output logic [W-1:0]      pub_key,
  output logic              pub_valid,
  output logic [W-1:0]      shared_key,
  output logic              shared_valid,
  output logic              busy,
  output logic              error,
  output logic [1:0]        err_code,
  dh_session_ctrl_if.master eng
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ErrPriv    = 2'd1;
  localparam logic [1:0] ErrPeer    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StPubLoad, StPubWait, StPeerWait, StShrLoad, StShrWait, StDone, StErr
  } state_e;

  state_e state_q, state_d;

  // The engine operand registers double as the captured session operands: g/p/a are
  // loaded on accepted start, B overwrites the base at the peer handshake.
  logic [W-1:0]    eng_base_q, eng_base_d;
  logic [W:0]      eng_exp_q, eng_exp_d;
  logic [W-1:0]    eng_prime_q, eng_prime_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    pub_key_q, pub_key_d;
  logic [W-1:0]    shared_key_q, shared_key_d;
  logic            pub_valid_q, pub_valid_d;
  logic            shared_valid_q, shared_valid_d;
  logic            error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            eng_load;

  logic wait_st, guard, eng_done, timeout, peer_ok;

  assign wait_st  = (state_q == StPubWait) || (state_q == StShrWait);
  // First WAIT cycle: the engine may not have raised eng_busy yet.
  assign guard    = (cnt_q == '0);
  assign eng_done = wait_st && !guard && !eng.eng_busy;
  assign timeout  = wait_st && !eng_done && (cnt_q == CntW'(TIMEOUT - 1));
  // p < 4 would make p-2 < 2 (or wrap), so reject every B explicitly.
  assign peer_ok  = (eng_prime_q >= W'(4)) && (peer_pub >= W'(2)) &&
                    (peer_pub <= (eng_prime_q - W'(2)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (start) state_d = (priv == '0) ? StErr : StPubLoad;
        StPubLoad:  state_d = StPubWait;
        StPubWait: begin
          if (eng_done)     state_d = StPeerWait;
          else if (timeout) state_d = StErr;
        end
        StPeerWait: if (peer_valid) state_d = peer_ok ? StShrLoad : StErr;
        StShrLoad:  state_d = StShrWait;
        StShrWait: begin
          if (eng_done)     state_d = StDone;
          else if (timeout) state_d = StErr;
        end
        StDone:     state_d = StIdle;
        StErr:      state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy       = (state_q != StIdle);
    peer_ready = (state_q == StPeerWait);
    eng_load   = (state_q == StPubLoad) || (state_q == StShrLoad);
  end

  // Datapath next-state; abort freezes everything so status and keys survive it.
  always_comb begin
    eng_base_d     = eng_base_q;
    eng_exp_d      = eng_exp_q;
    eng_prime_d    = eng_prime_q;
    cnt_d          = cnt_q;
    pub_key_d      = pub_key_q;
    shared_key_d   = shared_key_q;
    pub_valid_d    = pub_valid_q;
    shared_valid_d = shared_valid_q;
    error_d        = error_q;
    err_code_d     = err_code_q;
    if (!abort) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            eng_base_d     = gen;
            eng_exp_d      = priv;
            eng_prime_d    = prime;
            pub_valid_d    = 1'b0;
            shared_valid_d = 1'b0;
            error_d        = 1'b0;
            err_code_d     = 2'd0;
            if (priv == '0) begin
              error_d    = 1'b1;
              err_code_d = ErrPriv;
            end
          end
        end
        StPubLoad, StShrLoad: cnt_d = '0;
        StPubWait: begin
          cnt_d = cnt_q + CntW'(1);
          if (eng_done) begin
            pub_key_d   = eng.eng_result;
            pub_valid_d = 1'b1;
          end else if (timeout) begin
            error_d    = 1'b1;
            err_code_d = ErrTimeout;
          end
        end
        StPeerWait: begin
          if (peer_valid) begin
            eng_base_d = peer_pub;
            if (!peer_ok) begin
              error_d    = 1'b1;
              err_code_d = ErrPeer;
            end
          end
        end
        StShrWait: begin
          cnt_d = cnt_q + CntW'(1);
          if (eng_done) begin
            shared_key_d   = eng.eng_result;
            shared_valid_d = 1'b1;
          end else if (timeout) begin
            error_d    = 1'b1;
            err_code_d = ErrTimeout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_base_q     <= '0;
      eng_exp_q      <= '0;
      eng_prime_q    <= '0;
      cnt_q          <= '0;
      pub_key_q      <= '0;
      shared_key_q   <= '0;
      pub_valid_q    <= 1'b0;
      shared_valid_q <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= 2'd0;
    end else begin
      eng_base_q     <= eng_base_d;
      eng_exp_q      <= eng_exp_d;
      eng_prime_q    <= eng_prime_d;
      cnt_q          <= cnt_d;
      pub_key_q      <= pub_key_d;
      shared_key_q   <= shared_key_d;
      pub_valid_q    <= pub_valid_d;
      shared_valid_q <= shared_valid_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
    end
  end

  assign pub_key        = pub_key_q;
  assign pub_valid      = pub_valid_q;
  assign shared_key     = shared_key_q;
  assign shared_valid   = shared_valid_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign eng.eng_base   = eng_base_q;
  assign eng.eng_exp    = eng_exp_q;
  assign eng.eng_prime  = eng_prime_q;
  assign eng.eng_load   = eng_load;

endmodule

// File: tb/tb_dh_session_ctrl.sv
// Self-checking bench for dh_session_ctrl: directed sessions against a behavioural
// exponentiation engine (fixed latency, optional hang), hand-computed expected keys.
module tb_dh_session_ctrl;
  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int          Latency = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         peer_valid = 1'b0;
  logic [W-1:0] gen = '0;
  logic [W-1:0] prime = '0;
  logic [W-1:0] peer_pub = '0;
  logic [W:0]   priv = '0;
  logic         peer_ready, pub_valid, shared_valid, busy, error;
  logic [W-1:0] pub_key, shared_key;
  logic [1:0]   err_code;

  int n_checks = 0;
  int n_pass = 0;
  int load_pulses = 0;
  int lp_snap;
  bit hang = 1'b0;

  logic         m_busy = 1'b0;
  logic [W-1:0] m_result = '0;
  int           m_cnt = 0;

  dh_session_ctrl_if #(.W(W)) eng_bus ();

  dh_session_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .gen          (gen),
    .prime        (prime),
    .priv         (priv),
    .peer_pub     (peer_pub),
    .peer_valid   (peer_valid),
    .peer_ready   (peer_ready),
    .pub_key      (pub_key),
    .pub_valid    (pub_valid),
    .shared_key   (shared_key),
    .shared_valid (shared_valid),
    .busy         (busy),
    .error        (error),
    .err_code     (err_code),
    .eng          (eng_bus)
  );

  always #5 clk = ~clk;

  assign eng_bus.eng_busy   = m_busy;
  assign eng_bus.eng_result = m_result;

  function automatic logic [W-1:0] modpow(logic [W-1:0] b, logic [W:0] e, logic [W-1:0] m);
    int r;
    int bb;
    int mm;
    r  = 1;
    bb = int'(b);
    mm = int'(m);
    if (mm == 0) return '0;
    for (int i = W; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[W-1:0];
  endfunction

  // Behavioural engine: load restarts it; busy drops Latency edges later unless hung.
  always @(posedge clk) begin
    if (eng_bus.eng_load) begin
      m_busy      <= 1'b1;
      m_cnt       <= Latency;
      m_result    <= modpow(eng_bus.eng_base, eng_bus.eng_exp, eng_bus.eng_prime);
      load_pulses <= load_pulses + 1;
    end else if (m_busy && !hang) begin
      if (m_cnt <= 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [W-1:0] g, input logic [W-1:0] p,
                               input logic [W:0] a);
    gen   = g;
    prime = p;
    priv  = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pub(input string tag);
    for (int i = 0; i < 40 && !pub_valid; i++) tick();
    check(tag, pub_valid, 1);
  endtask

  task automatic wait_shared(input string tag);
    for (int i = 0; i < 40 && !shared_valid; i++) tick();
    check(tag, shared_valid, 1);
  endtask

  task automatic send_peer(input logic [W-1:0] b);
    peer_pub   = b;
    peer_valid = 1'b1;
    tick();
    peer_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst busy", busy, 0);
    check("rst pub_valid", pub_valid, 0);
    check("rst error", error, 0);
    check("rst peer_ready", peer_ready, 0);
    check("rst eng_load", eng_bus.eng_load, 0);
    rst = 1'b0;
    tick();

    // Normal session: 5^6 mod 23 = 8, 19^6 mod 23 = 2
    start_session(8'd5, 8'd23, 9'd6);
    check("pub_load eng_load", eng_bus.eng_load, 1);
    check("pub_load busy", busy, 1);
    check("pub_load eng_base", eng_bus.eng_base, 5);
    check("pub_load eng_exp", eng_bus.eng_exp, 6);
    check("pub_load eng_prime", eng_bus.eng_prime, 23);
    tick();
    check("guard eng_load", eng_bus.eng_load, 0);
    check("pub_wait peer_ready", peer_ready, 0);
    // start while busy is ignored
    start_session(8'd3, 8'd23, 9'd0);
    check("start busy ignored error", error, 0);
    check("start busy ignored base", eng_bus.eng_base, 5);
    wait_pub("s1 pub_valid");
    check("s1 pub_key", pub_key, 8);
    check("s1 peer_ready", peer_ready, 1);
    send_peer(8'd19);
    check("s1 peer_ready drop", peer_ready, 0);
    check("shr_load eng_load", eng_bus.eng_load, 1);
    check("shr_load eng_base", eng_bus.eng_base, 19);
    check("shr_load eng_exp", eng_bus.eng_exp, 6);
    wait_shared("s1 shared_valid");
    check("s1 shared_key", shared_key, 2);
    check("s1 error", error, 0);
    check("s1 done busy", busy, 1);
    tick();
    check("s1 idle busy", busy, 0);
    check("s1 hold shared_valid", shared_valid, 1);
    check("s1 hold pub_valid", pub_valid, 1);

    // Bad peer keys: B=1 then B=22 (p-1)
    start_session(8'd5, 8'd23, 9'd6);
    wait_pub("s2 pub_valid");
    send_peer(8'd1);
    check("b1 error", error, 1);
    check("b1 err_code", err_code, 2);
    check("b1 shared_valid", shared_valid, 0);
    check("b1 peer_ready", peer_ready, 0);
    check("b1 keep pub_key", pub_key, 8);
    tick();
    check("b1 idle busy", busy, 0);
    check("b1 sticky error", error, 1);
    start_session(8'd5, 8'd23, 9'd6);
    check("s3 error cleared", error, 0);
    wait_pub("s3 pub_valid");
    send_peer(8'd22);
    check("b22 error", error, 1);
    check("b22 err_code", err_code, 2);
    check("b22 shared_valid", shared_valid, 0);
    tick();

    // priv = 0
    lp_snap = load_pulses;
    start_session(8'd5, 8'd23, 9'd0);
    check("priv0 error", error, 1);
    check("priv0 err_code", err_code, 1);
    tick();
    check("priv0 idle busy", busy, 0);
    check("priv0 no eng_load", load_pulses, lp_snap);

    // Engine timeout: error appears 16 cycles after the guard cycle
    hang = 1'b1;
    start_session(8'd5, 8'd23, 9'd6);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("to early error", error, 0);
    check("to early busy", busy, 1);
    tick();
    check("to error", error, 1);
    check("to err_code", err_code, 3);
    tick();
    check("to idle busy", busy, 0);
    hang = 1'b0;
    start_session(8'd5, 8'd23, 9'd6);
    wait_pub("s4 pub_valid");
    check("s4 pub_key", pub_key, 8);
    send_peer(8'd19);
    wait_shared("s4 shared_valid");
    check("s4 shared_key", shared_key, 2);
    check("s4 error", error, 0);
    tick();

    // Abort during SHR_WAIT
    start_session(8'd5, 8'd23, 9'd6);
    wait_pub("s5 pub_valid");
    send_peer(8'd19);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort eng_load", eng_bus.eng_load, 0);
    check("abort shared_valid", shared_valid, 0);
    check("abort keep pub_valid", pub_valid, 1);
    check("abort error", error, 0);
    // abort beats start in IDLE
    abort = 1'b1;
    start_session(8'd5, 8'd23, 9'd6);
    abort = 1'b0;
    check("abort+start busy", busy, 0);
    check("abort+start pub_valid", pub_valid, 1);
    // Upper boundary B = p-2 = 21: 21^6 mod 23 = 18
    start_session(8'd5, 8'd23, 9'd6);
    wait_pub("s6 pub_valid");
    check("s6 pub_key", pub_key, 8);
    send_peer(8'd21);
    check("b21 no error", error, 0);
    wait_shared("s6 shared_valid");
    check("s6 shared_key", shared_key, 18);
    tick();

    // Asynchronous reset mid-PUB_WAIT
    start_session(8'd5, 8'd23, 9'd6);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst busy", busy, 0);
    check("arst shared_key", shared_key, 0);
    check("arst shared_valid", shared_valid, 0);
    check("arst eng_base", eng_bus.eng_base, 0);
    check("arst eng_prime", eng_bus.eng_prime, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post rst busy", busy, 0);
    check("post rst error", error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
